// File: rtl/control_conv_seq_if.sv
// Handshake and accumulator-control signals of the convolution sequencer.
// master: the sequencer; slave: sample source, result consumer and accumulator.
interface control_conv_seq_if #(
  parameter int LG_FILTER_N = 2
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   shift_en;
  logic                   in_compute;
  logic [LG_FILTER_N-1:0] mac_sel;
  logic                   done_acc;
  logic                   curr_comp_done;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;

  modport master (
    input  in_valid, out_ready, done_acc,
    output in_ready, shift_en, in_compute, mac_sel, curr_comp_done,
           out_valid, out_last
  );

  modport slave (
    output in_valid, out_ready, done_acc,
    input  in_ready, shift_en, in_compute, mac_sel, curr_comp_done,
           out_valid, out_last
  );
endinterface

// File: rtl/control_conv_seq.sv
// Convolution sequencer: fill/slide the sample window, run FILTER_N MAC taps, hand off each result.
// Optional accumulator interface checker enabled by defining CONV_SEQ_ACC_CHK_EN.
module control_conv_seq #(
  parameter int FILTER_N    = 4,
  parameter int LG_FILTER_N = 2,
  parameter int OUT_N       = 13,
  parameter int LG_OUT_N    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  control_conv_seq_if.master        bus,
  output logic                      busy,
  output logic                      run_done,
  output logic                      acc_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL    = 3'd1,
    COMPUTE = 3'd2,
    DRAIN   = 3'd3,
    OUTPUT  = 3'd4,
    SLIDE   = 3'd5
  } state_t;

  localparam logic [LG_FILTER_N-1:0] TAP_LAST = LG_FILTER_N'(FILTER_N - 1);
  localparam logic [LG_OUT_N-1:0]    OUT_LAST = LG_OUT_N'(OUT_N - 1);

  state_t                 state;
  logic [LG_FILTER_N-1:0] fill_cnt;
  logic [LG_FILTER_N-1:0] tap;
  logic [LG_OUT_N-1:0]    out_cnt;
  logic                   in_ready_r;
  logic                   in_compute_r;
  logic                   out_valid_r;
  logic                   out_last_r;
  logic                   accept;
  logic                   out_hs;

  assign accept = bus.in_valid & in_ready_r;
  assign out_hs = out_valid_r & bus.out_ready;

  // Every control output except the handshake-qualified ones is a registered decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      fill_cnt     <= '0;
      tap          <= '0;
      out_cnt      <= '0;
      in_ready_r   <= 1'b0;
      in_compute_r <= 1'b0;
      out_valid_r  <= 1'b0;
      out_last_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= FILL;
            fill_cnt   <= '0;
            out_cnt    <= '0;
            in_ready_r <= 1'b1;
          end
        end
        FILL: begin
          if (accept) begin
            if (fill_cnt == TAP_LAST) begin
              state        <= COMPUTE;
              fill_cnt     <= '0;
              in_ready_r   <= 1'b0;
              in_compute_r <= 1'b1;
              tap          <= '0;
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
        end
        COMPUTE: begin
          if (tap == TAP_LAST) begin
            state        <= DRAIN;
            in_compute_r <= 1'b0;
            tap          <= '0;
          end else begin
            tap <= tap + 1'b1;
          end
        end
        DRAIN: begin
          // The accumulator lands its last product this cycle; the result is ready next.
          state       <= OUTPUT;
          out_valid_r <= 1'b1;
          out_last_r  <= (out_cnt == OUT_LAST);
        end
        OUTPUT: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_cnt     <= out_cnt + 1'b1;
            if (out_last_r) begin
              state <= IDLE;
            end else begin
              state      <= SLIDE;
              in_ready_r <= 1'b1;
            end
          end
        end
        SLIDE: begin
          if (accept) begin
            state        <= COMPUTE;
            in_ready_r   <= 1'b0;
            in_compute_r <= 1'b1;
            tap          <= '0;
          end
        end
        default: begin
          state        <= IDLE;
          in_ready_r   <= 1'b0;
          in_compute_r <= 1'b0;
          out_valid_r  <= 1'b0;
          out_last_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready       = in_ready_r;
  assign bus.shift_en       = accept;
  assign bus.in_compute     = in_compute_r;
  assign bus.mac_sel        = tap;
  assign bus.out_valid      = out_valid_r;
  assign bus.out_last       = out_last_r;
  assign bus.curr_comp_done = out_hs;
  assign run_done           = out_hs & out_last_r;
  assign busy               = (state != IDLE);

`ifdef CONV_SEQ_ACC_CHK_EN
  logic acc_err_r;
  logic last_tap;
  logic acc_viol;

  // done_acc must coincide exactly with the final tap and be low everywhere else.
  assign last_tap = in_compute_r & (tap == TAP_LAST);
  assign acc_viol = last_tap ? ~bus.done_acc : bus.done_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_err_r <= 1'b0;
    end else if (state == IDLE && start) begin
      acc_err_r <= acc_viol;
    end else if (acc_viol) begin
      acc_err_r <= 1'b1;
    end
  end

  assign acc_err = acc_err_r;
`else
  logic unused_done_acc;
  assign unused_done_acc = bus.done_acc;
  assign acc_err         = 1'b0;
`endif

endmodule

// File: tb/tb_control_conv_seq.sv
// Scoreboard bench for control_conv_seq: default build plus an OUT_N=1 instance.
module tb_control_conv_seq;

`ifdef CONV_SEQ_ACC_CHK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic start0, start1;
  logic busy0, busy1, run_done0, run_done1, acc_err0, acc_err1;
  logic acc_mode;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  int q_comp [2][$];
  int q_hs   [2][$];
  int q_rd   [2][$];
  int shift_cnt [2];

  control_conv_seq_if #(.LG_FILTER_N(2)) bus0 ();
  control_conv_seq_if #(.LG_FILTER_N(2)) bus1 ();

  control_conv_seq #(.FILTER_N(4), .LG_FILTER_N(2), .OUT_N(13), .LG_OUT_N(4)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .bus(bus0),
    .busy(busy0), .run_done(run_done0), .acc_err(acc_err0)
  );

  control_conv_seq #(.FILTER_N(4), .LG_FILTER_N(2), .OUT_N(1), .LG_OUT_N(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .bus(bus1),
    .busy(busy1), .run_done(run_done1), .acc_err(acc_err1)
  );

  // Accumulator model: done_acc on the final tap; acc_mode=1 ties it low.
  assign bus0.done_acc = acc_mode ? 1'b0 : (bus0.in_compute && bus0.mac_sel == 2'd3);
  assign bus1.done_acc = bus1.in_compute && bus1.mac_sel == 2'd3;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: cycle %0d reached, required finish earlier", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push_run(input int d, input int cs, input int stall, input int n);
    int c;
    int hs;
    c = cs;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) q_comp[d].push_back((c + k) * 4 + k);
      hs = c + 5 + ((i == 0) ? stall : 0);
      q_hs[d].push_back(hs * 2 + ((i == n - 1) ? 1 : 0));
      if (i == n - 1) q_rd[d].push_back(hs);
      c = hs + 2;
    end
  endtask

  task automatic chk_drained(input int d, input string name);
    chk({name, "_compute_left"}, q_comp[d].size(), 0);
    chk({name, "_output_left"}, q_hs[d].size(), 0);
    chk({name, "_run_done_left"}, q_rd[d].size(), 0);
  endtask

  task automatic pulse_start0(output int t);
    t = cyc;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
  endtask

  task automatic mon(input int d, input logic ov, input logic ordy, input logic ol,
                     input logic ccd, input logic ic, input logic [1:0] ms,
                     input logic ir, input logic iv, input logic sh, input logic rd);
    int  e;
    logic hs;
    hs = ov & ordy;
    if (ic) begin
      e = (q_comp[d].size() != 0) ? q_comp[d].pop_front() : -1;
      chk($sformatf("d%0d compute_cycle_x4_plus_tap", d), cyc * 4 + int'(ms), e);
    end else begin
      chk($sformatf("d%0d mac_sel_outside_compute", d), int'(ms), 0);
    end
    if (hs) begin
      e = (q_hs[d].size() != 0) ? q_hs[d].pop_front() : -1;
      chk($sformatf("d%0d output_cycle_x2_plus_last", d), cyc * 2 + int'(ol), e);
      chk($sformatf("d%0d in_compute_at_handshake", d), int'(ic), 0);
    end
    if (ccd || hs) chk($sformatf("d%0d curr_comp_done_vs_handshake", d), int'(ccd), int'(hs));
    if (ov) chk($sformatf("d%0d in_ready_during_output", d), int'(ir), 0);
    if (rd) begin
      e = (q_rd[d].size() != 0) ? q_rd[d].pop_front() : -1;
      chk($sformatf("d%0d run_done_cycle", d), cyc, e);
    end
    if (iv) chk($sformatf("d%0d shift_en", d), int'(sh), int'(ir));
    if (sh) shift_cnt[d]++;
  endtask

  always @(negedge clk) begin
    mon(0, bus0.out_valid, bus0.out_ready, bus0.out_last, bus0.curr_comp_done, bus0.in_compute,
        bus0.mac_sel, bus0.in_ready, bus0.in_valid, bus0.shift_en, run_done0);
    mon(1, bus1.out_valid, bus1.out_ready, bus1.out_last, bus1.curr_comp_done, bus1.in_compute,
        bus1.mac_sel, bus1.in_ready, bus1.in_valid, bus1.shift_en, run_done1);
  end

  initial begin
    int t0;
    int t1;
    int n;
    logic [10:0] v;

    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; acc_mode = 1'b0;
    bus0.in_valid = 1'b1; bus0.out_ready = 1'b1;
    bus1.in_valid = 1'b1; bus1.out_ready = 1'b1;
    shift_cnt[0] = 0; shift_cnt[1] = 0;
    tick(); tick(); tick();
    v = {bus0.in_ready, bus0.shift_en, bus0.in_compute, bus0.mac_sel, bus0.curr_comp_done,
         bus0.out_valid, bus0.out_last, busy0, run_done0, acc_err0};
    chk("reset_outputs_dut0", int'(v), 0);
    v = {bus1.in_ready, bus1.shift_en, bus1.in_compute, bus1.mac_sel, bus1.curr_comp_done,
         bus1.out_valid, bus1.out_last, busy1, run_done1, acc_err1};
    chk("reset_outputs_dut1", int'(v), 0);
    reset = 1'b0;
    tick();

    // Continuous run, with a start pulse while busy that must be ignored.
    pulse_start0(t0);
    push_run(0, t0 + 5, 0, 13);
    wait_cyc(t0 + 20);
    start0 = 1'b1; tick(); start0 = 1'b0;
    wait_cyc(t0 + 94);
    chk("t1_busy_at_run_done", int'(busy0), 1);
    chk("t1_run_done_level", int'(run_done0), 1);
    wait_cyc(t0 + 95);
    chk("t1_busy_after_run_done", int'(busy0), 0);
    chk("t1_acc_err_good_model", int'(acc_err0), 0);
    wait_cyc(t0 + 97);
    chk_drained(0, "t1");

    // Three-cycle input gap during fill.
    pulse_start0(t0);
    shift_cnt[0] = 0;
    push_run(0, t0 + 8, 0, 13);
    wait_cyc(t0 + 3); bus0.in_valid = 1'b0;
    wait_cyc(t0 + 6); bus0.in_valid = 1'b1;
    wait_cyc(t0 + 8);
    chk("t2_shift_en_before_compute", shift_cnt[0], 4);
    wait_cyc(t0 + 100);
    chk_drained(0, "t2");

    // Consumer stalls the first result for five cycles.
    pulse_start0(t0);
    push_run(0, t0 + 5, 5, 13);
    n = 0;
    for (int k = 10; k <= 16; k++) begin
      wait_cyc(t0 + k);
      if (k == 10) bus0.out_ready = 1'b0;
      if (k == 15) bus0.out_ready = 1'b1;
      n += int'(bus0.out_valid);
    end
    chk("t3_out_valid_cycles", n, 6);
    wait_cyc(t0 + 102);
    chk_drained(0, "t3");

    // Reset while mac_sel=2, then a fresh run.
    pulse_start0(t0);
    for (int k = 0; k < 3; k++) q_comp[0].push_back((t0 + 5 + k) * 4 + k);
    wait_cyc(t0 + 7);
    chk("t4_mac_sel_before_reset", int'(bus0.mac_sel), 2);
    reset = 1'b1;
    tick();
    v = {bus0.in_ready, bus0.shift_en, bus0.in_compute, bus0.mac_sel, bus0.curr_comp_done,
         bus0.out_valid, bus0.out_last, busy0, run_done0, acc_err0};
    chk("t4_outputs_after_reset", int'(v), 0);
    reset = 1'b0;
    tick();
    chk_drained(0, "t4a");
    pulse_start0(t1);
    push_run(0, t1 + 5, 0, 13);
    wait_cyc(t1 + 97);
    chk_drained(0, "t4b");

    // done_acc tied low for a whole run, then cleared by the next start.
    acc_mode = 1'b1;
    pulse_start0(t0);
    push_run(0, t0 + 5, 0, 13);
    wait_cyc(t0 + 8);
    chk("t5_acc_err_before_last_tap", int'(acc_err0), 0);
    wait_cyc(t0 + 9);
    chk("t5_acc_err_after_last_tap", int'(acc_err0), CHK);
    wait_cyc(t0 + 60);
    chk("t5_acc_err_sticky", int'(acc_err0), CHK);
    wait_cyc(t0 + 97);
    chk("t5_acc_err_in_idle", int'(acc_err0), CHK);
    chk_drained(0, "t5a");
    acc_mode = 1'b0;
    pulse_start0(t1);
    chk("t5_acc_err_cleared_by_start", int'(acc_err0), 0);
    push_run(0, t1 + 5, 0, 13);
    wait_cyc(t1 + 97);
    chk("t5_acc_err_good_model", int'(acc_err0), 0);
    chk_drained(0, "t5b");

    // Single-output build with a start while busy.
    t0 = cyc;
    start1 = 1'b1; tick(); start1 = 1'b0;
    push_run(1, t0 + 5, 0, 1);
    wait_cyc(t0 + 3);
    start1 = 1'b1; tick(); start1 = 1'b0;
    wait_cyc(t0 + 10);
    chk("t6_busy_at_output", int'(busy1), 1);
    wait_cyc(t0 + 11);
    chk("t6_busy_after_output", int'(busy1), 0);
    chk("t6_no_slide", int'(bus1.in_ready), 0);
    wait_cyc(t0 + 20);
    chk("t6_still_idle", int'(busy1), 0);
    chk_drained(1, "t6");
    chk_drained(0, "final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
